ipu_result_queue: RTL and testbench

IPU_RESULT_QUEUE -- requirements
Module: ipu_result_queue

---
 rtl/ipu_result_queue.sv | 151 +++++++++++++++
 tb/tb_ipu_result_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ipu_result_queue.sv
// Detection result FIFO with a 4-word bus register window.
// Results are queued per accepted channel; each DATA read access pops one head entry.
module ipu_result_queue #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0200,
  parameter int          COORD_W   = 10,
  parameter int          DEPTH     = 8,
  parameter int          NUM_CH    = 2,
  localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [CH_W-1:0]    in_ch,
  input  logic               in_present,
  input  logic [COORD_W-1:0] in_row,
  input  logic [COORD_W-1:0] in_col,
  input  logic               write_i,
  input  logic               read_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  inout  wire  [31:0]        data_o,
  inout  wire                ack_o,
  output logic               irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 2*COORD_W + 1 + CH_W;

  logic [EW-1:0]          mem [DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr, count;
  logic                   empty, full;
  logic                   en, mode, irq_en, ovf, rd_q;
  logic [NUM_CH-1:0]      mask;
  logic [(1<<CH_W)-1:0]   mask_ext;
  logic [15:0]            drop_cnt;
  logic [31:0]            hold, live, status, ctrl_rd, rdata;
  logic                   sel, rd_start, pop, acc, push, adv, drop;
  logic [1:0]             word;
  logic                   wr_status, wr_ctrl, wr_drop;
  logic                   unused_ok;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign word      = addr_i[3:2];
  assign sel       = (addr_i[31:4] == BASE_ADDR[31:4]) && (read_i || write_i);
  assign rd_start  = sel && read_i && !rd_q && (word == 2'd0);
  assign pop       = rd_start && !empty;
  assign wr_status = sel && write_i && (word == 2'd1);
  assign wr_ctrl   = sel && write_i && (word == 2'd2);
  assign wr_drop   = sel && write_i && (word == 2'd3);
  assign unused_ok = ^{addr_i, data_i};

  always_comb begin
    mask_ext = '0;
    mask_ext[NUM_CH-1:0] = mask;
  end
  assign acc = in_valid && en && mask_ext[in_ch];

  // A full queue only loses data when nothing is popped on the same edge.
  always_comb begin
    push = 1'b0;
    adv  = 1'b0;
    drop = 1'b0;
    if (acc) begin
      if (pop) begin
        push = 1'b1;
        adv  = 1'b1;
      end else if (!full) begin
        push = 1'b1;
      end else if (mode) begin
        push = 1'b1;
        adv  = 1'b1;
        drop = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (pop) begin
      adv = 1'b1;
    end
  end

  always_comb begin
    live = '0;
    if (!empty) begin
      live[EW-1:0] = mem[rd_ptr[AW-1:0]];
      live[31]     = 1'b1;
    end
    status      = '0;
    status[6:0] = 7'(count);
    status[8]   = empty;
    status[9]   = full;
    status[10]  = ovf;
    ctrl_rd     = '0;
    ctrl_rd[0]  = en;
    ctrl_rd[1]  = mode;
    ctrl_rd[2]  = irq_en;
    ctrl_rd[8 +: NUM_CH] = mask;
    // Past the first cycle of an access, show the head captured before the pop.
    case (word)
      2'd0:    rdata = rd_q ? hold : live;
      2'd1:    rdata = status;
      2'd2:    rdata = ctrl_rd;
      default: rdata = {16'h0, drop_cnt};
    endcase
  end

  assign data_o = (sel && read_i) ? rdata : 32'bz;
  assign ack_o  = sel ? 1'b1 : 1'bz;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
      irq_o    <= 1'b0;
      rd_q     <= 1'b0;
      hold     <= '0;
      en       <= 1'b1;
      mode     <= 1'b0;
      irq_en   <= 1'b0;
      mask     <= '1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (adv)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)
        ovf <= 1'b1;
      else if (wr_status && data_i[10])
        ovf <= 1'b0;
      if (wr_drop)
        drop_cnt <= '0;
      else if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (wr_ctrl) begin
        en     <= data_i[0];
        mode   <= data_i[1];
        irq_en <= data_i[2];
        mask   <= data_i[8 +: NUM_CH];
      end
      if (rd_start) hold <= live;
      rd_q  <= read_i;
      irq_o <= irq_en && (!empty || ovf);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_ch, in_present, in_row, in_col};
  end
endmodule

// File: tb/tb_ipu_result_queue.sv
// Bench for ipu_result_queue: queue-based reference model plus directed scenarios.
module tb_ipu_result_queue;
  localparam logic [31:0] BASE = 32'h4000_0200;
  localparam int CW = 10, DEPTH = 8, NUM_CH = 2;
  localparam logic [31:0] A_DATA = BASE, A_STAT = BASE + 4, A_CTRL = BASE + 8, A_DROP = BASE + 12;

  logic sys_clk = 0, rst_n = 0;
  logic in_valid = 0, in_ch = 0, in_present = 0;
  logic [CW-1:0] in_row = 0, in_col = 0;
  logic write_i = 0, read_i = 0;
  logic [31:0] addr_i = 0, data_i = 0;
  wire  [31:0] data_o;
  wire         ack_o;
  logic        irq_o;
  int n_pass = 0, n_total = 0;

  always #5 sys_clk = ~sys_clk;

  ipu_result_queue #(.BASE_ADDR(BASE), .COORD_W(CW), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch),
    .in_present(in_present), .in_row(in_row), .in_col(in_col), .write_i(write_i),
    .read_i(read_i), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .ack_o(ack_o), .irq_o(irq_o));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference model: a plain queue of formatted entries plus register values.
  logic [31:0] mq [$];
  bit m_en, m_mode, m_irqen, m_ovf, m_prev_rd, m_irq;
  bit [1:0] m_mask;
  int m_drop;
  logic [31:0] m_hold;

  function automatic logic [31:0] m_live();
    return (mq.size() > 0) ? (32'h8000_0000 | mq[0]) : 32'h0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] w);
    case (w)
      2'd0: return m_prev_rd ? m_hold : m_live();
      2'd1: return 32'(mq.size()) | (32'(mq.size() == 0) << 8) |
                   (32'(mq.size() == DEPTH) << 9) | (32'(m_ovf) << 10);
      2'd2: return 32'(m_en) | (32'(m_mode) << 1) | (32'(m_irqen) << 2) | (32'(m_mask) << 8);
      default: return 32'(m_drop);
    endcase
  endfunction

  always @(posedge sys_clk or negedge rst_n) begin : model
    bit sel, rs, pop, acc, dropev, irq_n;
    logic [1:0] w;
    logic [31:0] e;
    if (!rst_n) begin
      mq.delete();
      m_en = 1; m_mode = 0; m_irqen = 0; m_mask = 2'b11;
      m_ovf = 0; m_drop = 0; m_prev_rd = 0; m_irq = 0; m_hold = 0;
    end else begin
      w   = addr_i[3:2];
      sel = (addr_i[31:4] == BASE[31:4]) && (read_i || write_i);
      rs  = sel && read_i && !m_prev_rd && (w == 2'd0);
      pop = rs && (mq.size() > 0);
      acc = in_valid && m_en && m_mask[in_ch];
      e   = {10'b0, in_ch, in_present, in_row, in_col};
      irq_n = m_irqen && ((mq.size() > 0) || m_ovf);
      if (rs) m_hold = m_live();
      dropev = 0;
      if (acc) begin
        if (pop) begin
          void'(mq.pop_front()); mq.push_back(e);
        end else if (mq.size() < DEPTH) begin
          mq.push_back(e);
        end else begin
          dropev = 1;
          if (m_mode) begin
            void'(mq.pop_front()); mq.push_back(e);
          end
        end
      end else if (pop) begin
        void'(mq.pop_front());
      end
      if (sel && write_i && w == 2'd1 && data_i[10]) m_ovf = 0;
      if (dropev) m_ovf = 1;
      if (dropev && m_drop < 65535) m_drop++;
      if (sel && write_i && w == 2'd3) m_drop = 0;
      if (sel && write_i && w == 2'd2) begin
        m_en = data_i[0]; m_mode = data_i[1]; m_irqen = data_i[2]; m_mask = data_i[9:8];
      end
      m_prev_rd = read_i;
      m_irq = irq_n;
    end
  end

  always @(negedge sys_clk) begin
    check("irq_o", {31'b0, irq_o}, {31'b0, m_irq});
    if ((addr_i[31:4] == BASE[31:4]) && (read_i || write_i)) begin
      check("ack_o", {31'b0, ack_o}, 32'h1);
      if (read_i) check("data_o", data_o, m_read(addr_i[3:2]));
    end
  end

  task automatic bus_rd(input logic [31:0] a, input int n, output logic [31:0] d);
    @(posedge sys_clk); #1;
    addr_i = a; read_i = 1;
    #1 d = data_o;
    repeat (n) @(posedge sys_clk);
    #1 read_i = 0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
    @(posedge sys_clk); #1;
    addr_i = a; data_i = v; write_i = 1;
    @(posedge sys_clk); #1 write_i = 0;
  endtask

  task automatic push(input logic ch, input logic [CW-1:0] row, input logic [CW-1:0] col);
    @(posedge sys_clk); #1;
    in_valid = 1; in_ch = ch; in_present = 1; in_row = row; in_col = col;
    @(posedge sys_clk); #1 in_valid = 0;
  endtask

  function automatic logic [31:0] ent(input logic ch, input logic [CW-1:0] row, input logic [CW-1:0] col);
    return 32'h8010_0000 | (32'(ch) << 21) | (32'(row) << 10) | 32'(col);
  endfunction

  initial begin : stim
    logic [31:0] d;
    #1 check("irq in reset", {31'b0, irq_o}, 32'h0);
    #20 rst_n = 1;
    bus_rd(A_STAT, 1, d); check("reset status", d, 32'h100);
    bus_rd(A_CTRL, 1, d); check("reset ctrl", d, 32'h301);
    bus_rd(A_DROP, 1, d); check("reset drop", d, 32'h0);

    // Basic push and pop order
    for (int i = 5; i <= 7; i++) push(0, CW'(i), 10'd9);
    bus_rd(A_STAT, 1, d); check("count3", d, 32'h3);
    bus_rd(A_DATA, 1, d); check("row5", d, 32'h8010_1409);
    bus_rd(A_DATA, 1, d); check("row6", d, 32'h8010_1809);
    bus_rd(A_DATA, 1, d); check("row7", d, 32'h8010_1C09);
    bus_rd(A_DATA, 1, d); check("empty read", d, 32'h0);
    bus_rd(A_STAT, 1, d); check("empty status", d, 32'h100);

    // Drop-new mode overflow
    for (int i = 0; i < 10; i++) push(0, CW'(i), 10'd1);
    bus_rd(A_STAT, 1, d); check("full status", d, 32'h608);
    bus_rd(A_DROP, 1, d); check("drop2", d, 32'h2);
    @(posedge sys_clk); #1;
    in_valid = 1; in_ch = 0; in_row = 30; in_col = 1;
    addr_i = A_DROP; write_i = 1;
    @(posedge sys_clk); #1 in_valid = 0; write_i = 0;
    bus_rd(A_DROP, 1, d); check("drop write wins", d, 32'h0);
    for (int i = 0; i < 8; i++) begin
      bus_rd(A_DATA, 1, d); check("mode0 order", d, ent(0, CW'(i), 10'd1));
    end
    bus_wr(A_STAT, 32'h400);
    bus_rd(A_STAT, 1, d); check("ovf clear", d, 32'h100);

    // Overwrite-oldest mode
    bus_wr(A_CTRL, 32'h303);
    for (int i = 0; i < 10; i++) push(0, CW'(i), 10'd1);
    bus_rd(A_DATA, 1, d); check("mode1 head", d, 32'h8010_0801);
    bus_rd(A_DROP, 1, d); check("mode1 drop", d, 32'h2);
    for (int i = 3; i < 10; i++) begin
      bus_rd(A_DATA, 1, d); check("mode1 order", d, ent(0, CW'(i), 10'd1));
    end
    bus_wr(A_STAT, 32'h400);
    bus_wr(A_DROP, 32'h0);

    // Channel mask filters ch0
    bus_wr(A_CTRL, 32'h201);
    push(0, 10'd1, 10'd0);
    push(1, 10'd2, 10'd0);
    bus_rd(A_STAT, 1, d); check("mask count", d, 32'h1);
    bus_rd(A_DATA, 1, d); check("mask head", d, 32'h8030_0800);
    bus_rd(A_DROP, 1, d); check("mask drop", d, 32'h0);
    bus_wr(A_CTRL, 32'h301);

    // Push coincident with a pop on a full queue; long read pops once
    for (int i = 10; i < 18; i++) push(0, CW'(i), 10'd0);
    @(posedge sys_clk); #1;
    in_valid = 1; in_ch = 0; in_row = 20; in_col = 0;
    addr_i = A_DATA; read_i = 1;
    #1 check("coinc head", data_o, ent(0, 10'd10, 10'd0));
    @(posedge sys_clk); #1 in_valid = 0;
    check("held head", data_o, ent(0, 10'd10, 10'd0));
    repeat (2) @(posedge sys_clk);
    #1 read_i = 0;
    bus_rd(A_STAT, 1, d); check("coinc status", d, 32'h208);
    bus_rd(A_DROP, 1, d); check("coinc drop", d, 32'h0);
    bus_rd(A_DATA, 1, d); check("single pop", d, ent(0, 10'd11, 10'd0));
    for (int i = 0; i < 7; i++) bus_rd(A_DATA, 1, d);
    check("last entry", d, ent(0, 10'd20, 10'd0));

    // Interrupt latency and reset mid-access
    bus_wr(A_CTRL, 32'h305);
    push(0, 10'd3, 10'd3);
    check("irq not yet", {31'b0, irq_o}, 32'h0);
    @(posedge sys_clk); #1 check("irq high", {31'b0, irq_o}, 32'h1);
    push(0, 10'd4, 10'd4);
    @(posedge sys_clk); #1;
    addr_i = A_DATA; read_i = 1;
    @(posedge sys_clk); #1 rst_n = 0;
    #1 check("irq async reset", {31'b0, irq_o}, 32'h0);
    addr_i = A_STAT; #1 check("status in reset", data_o, 32'h100);
    addr_i = A_DROP; #1 check("drop in reset", data_o, 32'h0);
    addr_i = A_CTRL; #1 check("ctrl in reset", data_o, 32'h301);
    read_i = 0;
    @(posedge sys_clk); #1 rst_n = 1;
    bus_rd(A_DATA, 1, d); check("empty after reset", d, 32'h0);
    bus_rd(A_STAT, 1, d); check("status after reset", d, 32'h100);

    repeat (2) @(posedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
